apu_pulse_bank: RTL and testbench

Parametrised successor to the single rectangle channel. It holds NUM_CH independent NES-style pulse channels, each with a duty sequencer, envelope, sweep unit and length counter. A byte-wide register write port and a channel-enable register (0x15 equivalent) drive the channels, and the block produces a registered, summed mix. It sits between the UART register decoder / frame counter and audio_pwm, which consumes the widened mix.

---
 rtl/apu_pulse_bank.sv | 194 +++++++++++++++++++
 tb/tb_apu_pulse_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_pulse_bank.sv
// Bank of NUM_CH NES-style pulse channels behind a byte-wide register port.
// Each channel has a duty sequencer, envelope, sweep and length counter; outputs are summed into a registered mix.
module apu_pulse_bank #(
  parameter int NUM_CH = 2,
  parameter int MIX_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_240hz,
  input  logic              enable_120hz,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [MIX_W-1:0]  mix,
  output logic [NUM_CH-1:0] active
);

  localparam logic [4:0] ENABLE_ADDR = 5'h15;

  // Field order matches the register bit layout, so a write is a plain cast.
  typedef struct packed {
    logic [1:0] duty;
    logic       halt;
    logic       const_vol;
    logic [3:0] vol;
  } ctrl_t;

  typedef struct packed {
    logic       en;
    logic [2:0] div_p;
    logic       negate;
    logic [2:0] shift;
  } sweep_cfg_t;

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] len_val;
    case (idx)
      5'd0:  len_val = 8'd10;   5'd1:  len_val = 8'd254;
      5'd2:  len_val = 8'd20;   5'd3:  len_val = 8'd2;
      5'd4:  len_val = 8'd40;   5'd5:  len_val = 8'd4;
      5'd6:  len_val = 8'd80;   5'd7:  len_val = 8'd6;
      5'd8:  len_val = 8'd160;  5'd9:  len_val = 8'd8;
      5'd10: len_val = 8'd60;   5'd11: len_val = 8'd10;
      5'd12: len_val = 8'd14;   5'd13: len_val = 8'd12;
      5'd14: len_val = 8'd26;   5'd15: len_val = 8'd14;
      5'd16: len_val = 8'd12;   5'd17: len_val = 8'd16;
      5'd18: len_val = 8'd24;   5'd19: len_val = 8'd18;
      5'd20: len_val = 8'd48;   5'd21: len_val = 8'd20;
      5'd22: len_val = 8'd96;   5'd23: len_val = 8'd22;
      5'd24: len_val = 8'd192;  5'd25: len_val = 8'd24;
      5'd26: len_val = 8'd72;   5'd27: len_val = 8'd26;
      5'd28: len_val = 8'd16;   5'd29: len_val = 8'd28;
      5'd30: len_val = 8'd32;   default: len_val = 8'd30;
    endcase
    return len_val;
  endfunction

  // Bit n of each pattern is the output level at sequencer step n.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pattern;
    case (duty)
      2'd0:    pattern = 8'b0000_0010;
      2'd1:    pattern = 8'b0000_0110;
      2'd2:    pattern = 8'b0001_1110;
      default: pattern = 8'b1111_1001;
    endcase
    return pattern[step];
  endfunction

  logic              presc_tick;
  logic [NUM_CH-1:0] en_reg;
  logic [3:0]        ch_out [NUM_CH];
  logic [MIX_W-1:0]  mix_next;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values and the order of statements inside a clocked block expresses priority, not evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_tick <= 1'b0;
      en_reg     <= '0;
      mix        <= '0;
    end else begin
      presc_tick <= ~presc_tick;
      if (wr_en && (wr_addr == ENABLE_ADDR)) en_reg <= wr_data[NUM_CH-1:0];
      mix <= mix_next;
    end
  end

  // NOTE: combinational blocks assign a default before any conditional logic so no path can leave a variable unassigned and infer a latch.
  always_comb begin
    mix_next = '0;
    for (int i = 0; i < NUM_CH; i++) mix_next = mix_next + MIX_W'(ch_out[i]);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [2:0]  CH_IDX  = 3'(i);
    // Channel 0 negates in ones' complement, the others in two's complement.
    localparam logic [11:0] NEG_ADJ = (i == 0) ? 12'd1 : 12'd0;

    ctrl_t       ctrl;
    sweep_cfg_t  sweep;
    logic        sweep_reload;
    logic [2:0]  sweep_div;
    logic [10:0] period;
    logic [10:0] timer;
    logic [2:0]  step;
    logic        env_start;
    logic [3:0]  env_decay;
    logic [3:0]  env_div;
    logic [7:0]  len;

    logic        sel;
    logic        wr_ctrl, wr_sweep, wr_lo, wr_hi;
    logic [11:0] delta, target;
    logic        mute, sweep_apply;
    logic [3:0]  volume;

    assign sel      = wr_en && (wr_addr[4:2] == CH_IDX);
    assign wr_ctrl  = sel && (wr_addr[1:0] == 2'd0);
    assign wr_sweep = sel && (wr_addr[1:0] == 2'd1);
    assign wr_lo    = sel && (wr_addr[1:0] == 2'd2);
    assign wr_hi    = sel && (wr_addr[1:0] == 2'd3);

    always_comb begin
      delta  = {1'b0, period} >> sweep.shift;
      target = sweep.negate ? ({1'b0, period} - delta - NEG_ADJ)
                            : ({1'b0, period} + delta);
    end

    // target[11] set means the raised period no longer fits in 11 bits.
    assign mute        = (period < 11'd8) || (!sweep.negate && target[11]);
    assign sweep_apply = enable_120hz && (sweep_div == 3'd0) && sweep.en &&
                         (sweep.shift != 3'd0) && !mute;
    assign volume      = ctrl.const_vol ? ctrl.vol : env_decay;
    assign ch_out[i]   = (duty_bit(ctrl.duty, step) && (len != 8'd0) && !mute && en_reg[i])
                         ? volume : 4'd0;
    assign active[i]   = (len != 8'd0);

    always_ff @(posedge clk) begin
      if (reset) begin
        ctrl         <= '0;
        sweep        <= '0;
        sweep_reload <= 1'b0;
        sweep_div    <= '0;
        period       <= '0;
        timer        <= '0;
        step         <= '0;
        env_start    <= 1'b0;
        env_decay    <= '0;
        env_div      <= '0;
        len          <= '0;
      end else begin
        if (wr_ctrl)  ctrl  <= ctrl_t'(wr_data);
        if (wr_sweep) sweep <= sweep_cfg_t'(wr_data);

        // A sweep update replaces the whole period and drops a same-clk write.
        if (sweep_apply)  period       <= target[10:0];
        else if (wr_lo)   period[7:0]  <= wr_data;
        else if (wr_hi)   period[10:8] <= wr_data[2:0];

        if (presc_tick) timer <= (timer == 11'd0) ? period : timer - 11'd1;

        if (wr_hi)                                  step <= 3'd0;
        else if (presc_tick && (timer == 11'd0))    step <= step + 3'd1;

        if (enable_240hz) begin
          if (env_start) begin
            env_start <= 1'b0;
            env_decay <= 4'd15;
            env_div   <= ctrl.vol;
          end else if (env_div == 4'd0) begin
            env_div <= ctrl.vol;
            if (env_decay != 4'd0) env_decay <= env_decay - 4'd1;
            else if (ctrl.halt)    env_decay <= 4'd15;
          end else begin
            env_div <= env_div - 4'd1;
          end
        end
        if (wr_hi) env_start <= 1'b1;

        if (!en_reg[i])                                        len <= 8'd0;
        else if (wr_hi)                                        len <= len_lut(wr_data[7:3]);
        else if (enable_120hz && (len != 8'd0) && !ctrl.halt)  len <= len - 8'd1;

        if (enable_120hz) begin
          if ((sweep_div == 3'd0) || sweep_reload) sweep_div <= sweep.div_p;
          else                                     sweep_div <= sweep_div - 3'd1;
        end
        if (wr_sweep)          sweep_reload <= 1'b1;
        else if (enable_120hz) sweep_reload <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_pulse_bank.sv
// Directed bench for apu_pulse_bank: a 2-channel and a 4-channel instance share one register bus.
// Expected values are queued as stimulus is issued and popped when the observation is taken.
module tb_apu_pulse_bank;

  localparam int LIM = 6000;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_240hz, enable_120hz;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] mix2, mix4;
  logic [1:0] active2;
  logic [3:0] active4;

  int exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  apu_pulse_bank #(.NUM_CH(2), .MIX_W(6)) dut (
    .clk(clk), .reset(reset), .enable_240hz(enable_240hz), .enable_120hz(enable_120hz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mix(mix2), .active(active2)
  );

  apu_pulse_bank #(.NUM_CH(4), .MIX_W(6)) dut4 (
    .clk(clk), .reset(reset), .enable_240hz(enable_240hz), .enable_120hz(enable_120hz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mix(mix4), .active(active4)
  );

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input int observed);
    int expected;
    tests_run++;
    expected = (exp_q.size() == 0) ? -2 : exp_q.pop_front();
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic strobe(input logic s120);
    enable_240hz = 1'b1; enable_120hz = s120;
    tick();
    enable_240hz = 1'b0; enable_120hz = 1'b0;
  endtask

  task automatic peak(input int n, output int p2, output int p4);
    p2 = 0; p4 = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (int'(mix2) > p2) p2 = int'(mix2);
      if (int'(mix4) > p4) p4 = int'(mix4);
    end
  endtask

  task automatic wait_nonzero(output int v);
    int n;
    n = 0;
    while (mix2 == 6'd0 && n < LIM) begin tick(); n++; end
    v = (n >= LIM) ? -1 : int'(mix2);
  endtask

  // Length of the next complete high run of mix2 and the low run after it.
  task automatic high_run(output int hi, output int lo);
    int n;
    hi = -1; lo = -1;
    tick(); tick();
    n = 0; while (mix2 != 6'd0 && n < LIM) begin tick(); n++; end
    if (n >= LIM) return;
    n = 0; while (mix2 == 6'd0 && n < LIM) begin tick(); n++; end
    if (n >= LIM) return;
    n = 0; while (mix2 != 6'd0 && n < LIM) begin tick(); n++; end
    if (n >= LIM) return;
    hi = n;
    n = 0; while (mix2 == 6'd0 && n < LIM) begin tick(); n++; end
    if (n >= LIM) return;
    lo = n;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, p2, p4, v, mx2, mx4, act;
    int duty_hi [4] = '{18, 36, 72, 108};

    reset = 1'b1; enable_240hz = 1'b0; enable_120hz = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle: no writes, frame strobes only.
    push(0); push(0); push(0);
    mx2 = 0; mx4 = 0; act = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) strobe(1'b1); else tick();
      if (int'(mix2) > mx2) mx2 = int'(mix2);
      if (int'(mix4) > mx4) mx4 = int'(mix4);
      act = act | int'(active2) | int'(active4);
    end
    check("idle_mix2", mx2);
    check("idle_mix4", mx4);
    check("idle_active", act);

    // 50% duty, constant volume 15, period 0x10 -> 34 clk per step.
    wr(5'h15, 8'h01); wr(5'd0, 8'hBF); wr(5'd2, 8'h10); wr(5'd3, 8'h08);
    push(136); push(136); push(1); push(1); push(15);
    high_run(hi, lo);
    check("pulse50_high", hi);
    check("pulse50_low", lo);
    check("pulse50_active2", int'(active2));
    check("pulse50_active4", int'(active4));
    peak(300, p2, p4);
    check("pulse50_peak", p2);

    // Reset while the note is sounding.
    push(15); push(0); push(0); push(0); push(0);
    wait_nonzero(v);
    check("pre_reset_mix", v);
    do_reset();
    check("reset_mix2", int'(mix2));
    check("reset_mix4", int'(mix4));
    check("reset_active2", int'(active2));
    check("reset_active4", int'(active4));

    // Duty patterns at period 8 (18 clk per step).
    wr(5'h15, 8'h01); wr(5'd2, 8'h08); wr(5'd3, 8'h08);
    for (int d = 0; d < 4; d++) begin
      wr(5'd0, {2'(d), 6'b11_1111});
      push(duty_hi[d]);
      high_run(hi, lo);
      check($sformatf("duty%0d_high", d), hi);
    end

    // Length counter: index 0 loads 10, halt clear.
    do_reset();
    wr(5'h15, 8'h01); wr(5'd0, 8'h9F); wr(5'd2, 8'h10); wr(5'd3, 8'h00);
    push(1); push(0); push(0);
    repeat (9) strobe(1'b1);
    check("len_after9", int'(active2));
    strobe(1'b1);
    check("len_after10", int'(active2));
    peak(300, p2, p4);
    check("len_expired_mix", p2);

    // Clearing the enable bit mid-note.
    wr(5'd3, 8'h08);
    push(15); push(0); push(0);
    wait_nonzero(v);
    check("en_pre_mix", v);
    wr(5'h15, 8'h00);
    tick();
    check("en_clear_mix", int'(mix2));
    check("en_clear_active", int'(active2));

    // Envelope, V=15, no loop, period 8.
    do_reset();
    wr(5'h15, 8'h01); wr(5'd0, 8'h8F); wr(5'd2, 8'h08); wr(5'd3, 8'h08);
    push(0); push(15); push(15); push(14); push(0); push(15);
    peak(160, p2, p4);
    check("env_before_strobe", p2);
    strobe(1'b0);
    peak(160, p2, p4);
    check("env_strobe1", p2);
    repeat (15) strobe(1'b0);
    peak(160, p2, p4);
    check("env_strobe16", p2);
    strobe(1'b0);
    peak(160, p2, p4);
    check("env_strobe17", p2);
    repeat (283) strobe(1'b0);
    peak(160, p2, p4);
    check("env_hold0", p2);
    wr(5'd0, 8'hAF);
    repeat (16) strobe(1'b0);
    peak(160, p2, p4);
    check("env_loop_wrap", p2);

    // Negating sweep, shift 1, period 0x100: ch0 -> 0x7F, ch1 -> 0x80.
    do_reset();
    wr(5'h15, 8'h01); wr(5'd0, 8'hBF); wr(5'd1, 8'h89); wr(5'd2, 8'h00); wr(5'd3, 8'h09);
    strobe(1'b1);
    push(4 * 2 * (16'h7F + 1));
    high_run(hi, lo);
    check("sweep_neg_ch0", hi);

    do_reset();
    wr(5'h15, 8'h02); wr(5'd4, 8'hBF); wr(5'd5, 8'h89); wr(5'd6, 8'h00); wr(5'd7, 8'h09);
    strobe(1'b1);
    push(4 * 2 * (16'h80 + 1));
    high_run(hi, lo);
    check("sweep_neg_ch1", hi);

    // Raising sweep: 0x400 -> 0x600 accepted, then target 0x900 mutes.
    do_reset();
    wr(5'h15, 8'h01); wr(5'd0, 8'hBF); wr(5'd1, 8'h81); wr(5'd2, 8'h00); wr(5'd3, 8'h0C);
    push(15); push(0);
    wait_nonzero(v);
    check("sweep_up_before", v);
    strobe(1'b1);
    peak(300, p2, p4);
    check("sweep_up_muted", p2);

    // All channels at V=15, duty 75%, period 100; ch2/ch3 addresses are absent in the 2-channel bank.
    do_reset();
    wr(5'h15, 8'h0F);
    for (int ch = 0; ch < 4; ch++) begin
      wr(5'(4 * ch + 0), 8'hFF);
      wr(5'(4 * ch + 2), 8'd100);
      wr(5'(4 * ch + 3), 8'h08);
    end
    push(60); push(30); push(15); push(3);
    peak(3400, p2, p4);
    check("mix4_peak", p4);
    check("mix2_peak", p2);
    check("all_active4", int'(active4));
    check("all_active2", int'(active2));

    // reg3 write (index 3 -> 2) coinciding with a 120 Hz strobe keeps the full table value.
    wr(5'd0, 8'h9F);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h18;
    enable_240hz = 1'b1; enable_120hz = 1'b1;
    tick();
    wr_en = 1'b0; enable_240hz = 1'b0; enable_120hz = 1'b0;
    push(15); push(3); push(14); push(2);
    strobe(1'b1);
    check("coinc_len_1_ch4", int'(active4));
    check("coinc_len_1_ch2", int'(active2));
    strobe(1'b1);
    check("coinc_len_2_ch4", int'(active4));
    check("coinc_len_2_ch2", int'(active2));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
